// File: rtl/sobel_pkg.sv
// sobel_pkg: shared definitions for the Sobel 3x3 window generator.
//   - default image geometry, RGB->grey coefficients, pixel type
//   - FSM state enum, stage-1 pipeline struct
//   - rgb2gray(): grey conversion; with GRAY_ROUND_EN defined the result is
//     rounded (+128 before the shift), otherwise truncated. Both builds share
//     the same latency because the function is purely combinational.
package sobel_pkg;

    localparam int IMG_W_DEF = 160;
    localparam int IMG_H_DEF = 120;

    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;

    typedef logic [7:0] pix_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } state_t;

    // Stage-1 register: grey pixel plus the two line-buffer words for its column.
    typedef struct packed {
        logic shift;
        pix_t gray;
        pix_t l1;
        pix_t l2;
    } s1_t;

    // Coefficients sum to 256, so the 16-bit sum never overflows (max 65408).
    function automatic pix_t rgb2gray(input pix_t r, input pix_t g, input pix_t b);
        logic [15:0] acc;
        acc = 16'(COEF_R) * 16'(r) + 16'(COEF_G) * 16'(g) + 16'(COEF_B) * 16'(b);
`ifdef GRAY_ROUND_EN
        acc = acc + 16'd128;
`else
        acc = acc + 16'd0;
`endif
        return acc[15:8];
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: single-port line buffer, DEPTH x 8 bit.
//   sys_clk_i : clock, rising edge
//   addr      : shared read/write address (column)
//   we        : write enable, write lands on the rising edge
//   wr_data   : word to store
//   rd_data   : word held at addr before this cycle's write (read-before-write);
//               the caller captures it in its first pipeline register.
// Contents are never reset; stale data is masked by the window-valid gating.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          sys_clk_i,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  pix_t          wr_data,
    output pix_t          rd_data
);

    pix_t mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge sys_clk_i) begin
        if (we) mem[addr] <= wr_data;
    end

endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: RGB stream -> 3x3 grey window for a Sobel filter.
//   sys_clk_i / sys_rst_ni : clock, async active-low reset
//   pix_valid_i, sof_i     : pixel strobe and start-of-frame (qualified by strobe)
//   data_{red,green,blue}_i: 8-bit colour channels
//   win_o                  : 3x3 window, [71:64]=p00 (oldest) .. [7:0]=p22 (newest)
//   win_valid_o            : window valid, 2 cycles after a pixel with row>=2, col>=2
//   frame_done_o           : 1-cycle pulse, 2 cycles after the last pixel of a frame
// Build option: GRAY_ROUND_EN selects rounded grey conversion (see sobel_pkg).
// Pipeline: stage 1 registers grey + both line-buffer words, stage 2 shifts the
// window. Only accepted pixels move data; the valid shift registers run every cycle.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_ni,
    input  logic        pix_valid_i,
    input  logic        sof_i,
    input  pix_t        data_red_i,
    input  pix_t        data_green_i,
    input  pix_t        data_blue_i,
    output logic [71:0] win_o,
    output logic        win_valid_o,
    output logic        frame_done_o
);

    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int STAGES = 2;

    state_t          state_q;
    logic [CW-1:0]   col_q, cur_col, nxt_col;
    logic [RW-1:0]   row_q, cur_row, nxt_row;
    logic            take, eol, last, win_gate;
    pix_t            gray;
    logic [1:0][7:0] lb_rd;
    s1_t             s1_q;
    logic [STAGES:1] vld_pipe, done_pipe;
    logic [8:0][7:0] win_q;

    // A pixel is taken when it starts a frame or belongs to a running one.
    // sof_i forces the pixel to index 0 regardless of the stored counters.
    always_comb begin
        take     = pix_valid_i && (sof_i || state_q == FILL || state_q == STREAM);
        cur_col  = sof_i ? '0 : col_q;
        cur_row  = sof_i ? '0 : row_q;
        eol      = (cur_col == CW'(IMG_W - 1));
        last     = eol && (cur_row == RW'(IMG_H - 1));
        nxt_col  = eol ? '0 : cur_col + CW'(1);
        nxt_row  = eol ? (last ? '0 : cur_row + RW'(1)) : cur_row;
        win_gate = take && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    end

    assign gray = rgb2gray(data_red_i, data_green_i, data_blue_i);

    // Cascaded line buffers: lb[0] holds the previous line, lb[1] the one before.
    for (genvar i = 0; i < 2; i++) begin : g_lb
        pix_t wr_d;
        if (i == 0) begin : g_head
            assign wr_d = gray;
        end else begin : g_tail
            assign wr_d = lb_rd[i-1];
        end
        sobel_line_buf #(
            .DEPTH (IMG_W),
            .AW    (CW)
        ) u_lb (
            .sys_clk_i (sys_clk_i),
            .addr      (cur_col),
            .we        (take),
            .wr_data   (wr_d),
            .rd_data   (lb_rd[i])
        );
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            if (take) begin
                col_q <= nxt_col;
                row_q <= nxt_row;
            end
            case (state_q)
                IDLE:    if (take) state_q <= FILL;
                FILL:    if (take && !sof_i && eol && cur_row == RW'(1)) state_q <= STREAM;
                STREAM:  if (take) begin
                             if (sof_i)     state_q <= FILL;
                             else if (last) state_q <= DONE;
                         end
                DONE:    state_q <= take ? FILL : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            vld_pipe  <= '0;
            done_pipe <= '0;
            s1_q      <= '0;
            win_q     <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], win_gate};
            done_pipe <= {done_pipe[STAGES-1:1], take && last};
            s1_q.shift <= take;
            if (take) begin
                s1_q.gray <= gray;
                s1_q.l1   <= lb_rd[0];
                s1_q.l2   <= lb_rd[1];
            end
            // Each row shifts left; new column is {line2, line1, gray}.
            if (s1_q.shift) begin
                win_q[8:6] <= {win_q[7:6], s1_q.l2};
                win_q[5:3] <= {win_q[4:3], s1_q.l1};
                win_q[2:0] <= {win_q[1:0], s1_q.gray};
            end
        end
    end

    assign win_o        = win_q;
    assign win_valid_o  = vld_pipe[STAGES];
    assign frame_done_o = done_pipe[STAGES];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: random/structured pixel streams checked against a
// frame-image reference model that builds each expected window from stored pixels.
module tb_sobel_window_gen;

    localparam int W = 160;
    localparam int H = 120;
`ifdef GRAY_ROUND_EN
    localparam int RED_EXP = 77;
`else
    localparam int RED_EXP = 76;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid, sof;
    logic [7:0]  red, green, blue;
    logic [71:0] win;
    logic        win_valid, frame_done;

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .sys_clk_i    (clk),
        .sys_rst_ni   (rst_n),
        .pix_valid_i  (pix_valid),
        .sof_i        (sof),
        .data_red_i   (red),
        .data_green_i (green),
        .data_blue_i  (blue),
        .win_o        (win),
        .win_valid_o  (win_valid),
        .frame_done_o (frame_done)
    );

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Reference model state
    bit          in_frame = 0;
    int          nxt_idx  = 0;
    int          img [H][W];
    logic        exp_v [4];
    logic        exp_d [4];
    logic [71:0] exp_w [4];
    int          cyc = 0;
    int          n_win = 0, n_done = 0;
    bit          got_first = 0;
    logic [71:0] first_win = '0;
    int          first_cyc = 0, acc22_cyc = 0;

    function automatic int gray_of(input int r, input int g, input int b);
        int v;
        v = 77 * r + 150 * g + 29 * b;
`ifdef GRAY_ROUND_EN
        v = v + 128;
`endif
        return v / 256;
    endfunction

    task automatic step(input bit v, input bit s, input int r, input int g, input int b);
        int slot, idx, row, col, ps;
        logic [71:0] w;
        @(negedge clk);
        cyc++;
        slot = cyc % 4;
        chk("win_valid", {71'd0, win_valid}, {71'd0, exp_v[slot]});
        if (exp_v[slot]) chk("win", win, exp_w[slot]);
        chk("frame_done", {71'd0, frame_done}, {71'd0, exp_d[slot]});
        if (win_valid) begin
            n_win++;
            if (!got_first) begin
                got_first = 1;
                first_win = win;
                first_cyc = cyc;
            end
        end
        if (frame_done) n_done++;
        exp_v[slot] = 1'b0;
        exp_d[slot] = 1'b0;
        pix_valid = v;
        sof       = s;
        red       = 8'(r);
        green     = 8'(g);
        blue      = 8'(b);
        if (v && (s || in_frame)) begin
            idx      = s ? 0 : nxt_idx;
            nxt_idx  = idx + 1;
            in_frame = 1;
            row      = idx / W;
            col      = idx % W;
            img[row][col] = gray_of(r, g, b);
            ps = (cyc + 2) % 4;
            if (row >= 2 && col >= 2) begin
                w = '0;
                for (int rr = row - 2; rr <= row; rr++)
                    for (int cc = col - 2; cc <= col; cc++)
                        w = {w[63:0], 8'(img[rr][cc])};
                exp_v[ps] = 1'b1;
                exp_w[ps] = w;
            end
            if (idx == 2 * W + 2) acc22_cyc = cyc;
            if (idx == W * H - 1) begin
                exp_d[ps] = 1'b1;
                in_frame  = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    function automatic int rnd8();
        return int'($urandom_range(255));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            exp_v[i] = 1'b0;
            exp_d[i] = 1'b0;
            exp_w[i] = '0;
        end
        rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0; red = '0; green = '0; blue = '0;
        repeat (2) @(negedge clk);
        chk("rst_win", win, 72'd0);
        chk("rst_win_valid", {71'd0, win_valid}, 72'd0);
        chk("rst_frame_done", {71'd0, frame_done}, 72'd0);
        rst_n = 1'b1;

        // Flat grey 100 for a whole frame
        n_win = 0; n_done = 0;
        for (int i = 0; i < W * H; i++) step(1, i == 0, 100, 100, 100);
        idle(3);
        chk("flat_windows", n_win, (W - 2) * (H - 2));
        chk("flat_done", n_done, 1);

        // Pure red
        for (int i = 0; i < 4 * W; i++) step(1, i == 0, 255, 0, 0);
        idle(3);
        chk("red_byte", {64'd0, win[7:0]}, RED_EXP);
        chk("red_p00", {64'd0, win[71:64]}, RED_EXP);

        // Grey equals column index
        got_first = 0;
        for (int i = 0; i < 3 * W + 10; i++) step(1, i == 0, i % W, i % W, i % W);
        idle(3);
        chk("col_first_win", first_win, 72'h000102_000102_000102);
        chk("col_first_lat", first_cyc - acc22_cyc, 2);

        // Random pixels, strobe toggling every cycle, 20 lines
        n_win = 0;
        for (int i = 0; i < 20 * W; i++) begin
            step(1, i == 0, rnd8(), rnd8(), rnd8());
            step(0, 0, rnd8(), rnd8(), rnd8());
        end
        idle(3);
        chk("toggle_windows", n_win, (W - 2) * 18);

        // Restart with sof at row 50
        n_win = 0; n_done = 0;
        for (int i = 0; i < 50 * W; i++) step(1, i == 0, rnd8(), rnd8(), rnd8());
        for (int i = 0; i < W * H - 1; i++) step(1, i == 0, rnd8(), rnd8(), rnd8());
        idle(2);
        chk("sof_no_early_done", n_done, 0);
        step(1, 0, rnd8(), rnd8(), rnd8());
        idle(3);
        chk("sof_done", n_done, 1);
        chk("sof_windows", n_win, 48 * (W - 2) + (W - 2) * (H - 2));

        // Reset pulse at row 10
        for (int i = 0; i < 10 * W + 5; i++) step(1, i == 0, rnd8(), rnd8(), rnd8());
        @(negedge clk);
        cyc++;
        rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0;
        #1;
        chk("midrst_win", win, 72'd0);
        chk("midrst_win_valid", {71'd0, win_valid}, 72'd0);
        chk("midrst_frame_done", {71'd0, frame_done}, 72'd0);
        for (int i = 0; i < 4; i++) begin
            exp_v[i] = 1'b0;
            exp_d[i] = 1'b0;
        end
        in_frame = 0;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        n_win = 0;
        for (int i = 0; i < 3 * W; i++) step(1, 0, rnd8(), rnd8(), rnd8());
        idle(3);
        chk("rst_no_win", n_win, 0);
        for (int i = 0; i < 2 * W + 3; i++) step(1, i == 0, rnd8(), rnd8(), rnd8());
        idle(3);
        chk("rst_resume_win", n_win, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 160, pixels per line.
REQ-002 SHALL have parameter IMG_H, default 120, lines per frame.
REQ-003 SHALL have port sys_clk_i, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port sys_rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port pix_valid_i, input, 1 bit: the RGB pixel is valid this cycle.
REQ-006 SHALL have port sof_i, input, 1 bit: start of frame, qualified by pix_valid_i.
REQ-007 SHALL have ports data_red_i, data_green_i and data_blue_i, input, 8 bits each: the pixel colour channels.
REQ-008 SHALL have port win_o, output, 72 bits: the 3x3 grey window.
  - Order: [71:64] is p00 (oldest row, oldest column), row-major, down to [7:0] p22 (newest pixel).
REQ-009 SHALL have port win_valid_o, output, 1 bit: win_o is valid this cycle.
REQ-010 SHALL have port frame_done_o, output, 1 bit: one-cycle pulse at end of frame.

Function
REQ-011 SHALL accept a pixel only on cycles where pix_valid_i=1; idle cycles stall every counter and register.
REQ-012 SHALL compute stage 1 as gray = (77*R + 150*G + 29*B) >> 8.
  - Unsigned, 16-bit intermediate, 8-bit result, no saturation needed.
REQ-013 SHALL implement two line buffers of depth IMG_W, read and written at the column counter (col) of the accepted pixel.
  - Written with the current grey value and the previous line's value.
REQ-014 SHALL shift the 3x3 window left by one column per accepted grey pixel in stage 2, loading the new column {line2, line1, gray}.
REQ-015 SHALL keep counters col (0..IMG_W-1) and row (0..IMG_H-1).
  - col wraps to 0 and row increments at col=IMG_W-1.
REQ-016 SHALL assert win_valid_o exactly 2 cycles after accepting a pixel with row>=2 and col>=2; otherwise 0.
  - Gives (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-017 SHALL use FSM states IDLE, FILL (row<2), STREAM and DONE.
  - IDLE->FILL: accepted pixel with sof_i=1.
  - FILL->STREAM: row reaches 2.
  - STREAM->DONE: last pixel (row=IMG_H-1, col=IMG_W-1) accepted.
  - DONE->IDLE: the following cycle.
REQ-018 SHALL pulse frame_done_o for one cycle, 2 cycles after the last pixel is accepted.
REQ-019 SHALL ignore pixels accepted in IDLE without sof_i=1.
REQ-020 SHALL, on sof_i=1 with pix_valid_i=1 in any state, treat that pixel as index 0 of a new frame.
  - col and row restart; pending win_valid_o already in the pipe still completes; no frame_done_o for the aborted frame.
REQ-021 SHALL not clear the line buffers at frame start; stale contents are masked by the REQ-016 gating.

Reset
REQ-022 SHALL, while sys_rst_ni=0, clear FSM to IDLE, col=0, row=0, win_o=0, win_valid_o=0, frame_done_o=0 and all pipeline valids, asynchronously.
REQ-023 SHALL, on reset mid-frame, discard the frame; the next output requires a new sof_i.

Configuration
REQ-024 SHALL, with GRAY_ROUND_EN defined, compute gray = (77*R + 150*G + 29*B + 128) >> 8.
  - Without GRAY_ROUND_EN: truncation per REQ-012.
  - Latency is identical in both builds.

Structure
REQ-025 SHALL place IMG_W/IMG_H defaults, the coefficients 77/150/29, the pixel type (8-bit) and the FSM state enum in shared package sobel_pkg.
REQ-026 SHALL instantiate the line buffer as sub-module sobel_line_buf.
  - Single-port synchronous RAM, depth IMG_W, 8-bit, read-before-write; instantiated twice.

Verification
REQ-027 SHALL cover: R=G=B=100 for a full frame -> every window byte 0x64, 18644 win_valid_o pulses, one frame_done_o.
REQ-028 SHALL cover: R=255, G=0, B=0 constant -> window bytes 76 without GRAY_ROUND_EN, 77 with it.
REQ-029 SHALL cover: gray = col index (R=G=B=col) -> at row 2, col 2: win_o rows each {0,1,2}, first win_valid_o 2 cycles after that pixel.
REQ-030 SHALL cover: pix_valid_i toggled 1/0 every cycle -> same window sequence and count as continuous input.
REQ-031 SHALL cover: sof_i reasserted at row 50 -> counters restart, no frame_done_o until 19200 further pixels accepted.
REQ-032 SHALL cover: sys_rst_ni low for 1 cycle at row 10 -> all outputs 0 immediately, no windows until a new sof_i plus 2 lines.
